// File: rtl/led_pwm_driver.sv
// LED PWM driver: accepts duty values over valid/ready, double-buffers them and
// drives a glitch-free PWM pin whose duty only changes at period boundaries.
module led_pwm_driver #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PRESCALE = 4,
    parameter bit          INVERT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] duty_in,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic             pwm_out,
    output logic             period_start
);

    localparam int unsigned      PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [PRE_W-1:0] r_pre_cnt;
    logic [WIDTH-1:0] r_pwm_cnt;
    logic [WIDTH-1:0] r_active_duty;
    logic [WIDTH-1:0] r_pending;
    logic             r_pending_full;
    logic             r_pwm_out;
    logic             r_period_start;

    logic             w_accept;
    logic             w_tick;
    logic             w_boundary;

    assign w_accept   = duty_valid && !r_pending_full;
    assign w_tick     = (r_state == ST_RUN) && en && (r_pre_cnt == PRE_MAX);
    assign w_boundary = w_tick && (r_pwm_cnt == CNT_MAX);

    assign duty_ready   = !r_pending_full;
    assign pwm_out      = r_pwm_out;
    assign period_start = r_period_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_pre_cnt      <= '0;
            r_pwm_cnt      <= '0;
            r_active_duty  <= '0;
            r_pending      <= '0;
            r_pending_full <= 1'b0;
            r_pwm_out      <= INVERT;
            r_period_start <= 1'b0;
        end else begin
            r_period_start <= 1'b0;
            if (w_accept) begin
                r_pending      <= duty_in;
                r_pending_full <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    r_pre_cnt <= '0;
                    r_pwm_cnt <= '0;
                    r_pwm_out <= INVERT;
                    // No accept can coincide with this load: accept needs an empty slot
                    if (r_pending_full) begin
                        r_active_duty  <= r_pending;
                        r_pending_full <= 1'b0;
                    end
                    if (en) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!en) begin
                        r_state   <= ST_IDLE;
                        r_pre_cnt <= '0;
                        r_pwm_cnt <= '0;
                        r_pwm_out <= INVERT;
                    end else begin
                        r_pwm_out <= (r_pwm_cnt < r_active_duty) ^ INVERT;
                        r_pre_cnt <= w_tick ? '0 : r_pre_cnt + PRE_W'(1);
                        if (w_tick) begin
                            r_pwm_cnt <= r_pwm_cnt + WIDTH'(1);
                        end
                        // Period boundary: buffered duty wins, else a same-cycle accept bypasses the slot
                        if (w_boundary) begin
                            r_period_start <= 1'b1;
                            if (r_pending_full) begin
                                r_active_duty  <= r_pending;
                                r_pending_full <= 1'b0;
                            end else if (w_accept) begin
                                r_active_duty  <= duty_in;
                                r_pending_full <= 1'b0;
                            end
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
